dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller for the processor's memory stage. It takes MemRead/MemWrite and the ALU result address from the execute stage, serves read hits in the same cycle, and stalls the pipeline while misses and write-throughs go over a req/ack backing-memory bus. It sits between the ALU and the data cache storage path and replaces direct array access for loads and stores.

---
 rtl/dcache_ctrl.sv | 152 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Serves read hits in the request cycle. Misses and stores stall the pipeline
// while a req/ack transaction runs on the backing-memory bus.
module dcache_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              flush,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int unsigned OFF_W  = 3;
  localparam int unsigned WORD_W = ADDR_W - OFF_W;
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned LINES  = 1 << IDX_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state_q, state_d;
  logic                done_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];
  logic [WORD_W-1:0]   lat_word_q;
  logic [DATA_W-1:0]   lat_data_q;
  logic [CNT_W-1:0]    hit_q, miss_q;

  logic [IDX_W-1:0]    idx, lat_idx;
  logic [TAG_W-1:0]    tag_in, lat_tag;
  logic                hit;
  logic                do_lat, do_wr_hit, do_fill, do_flush, inc_hit, inc_miss;
  logic                unused_lo;

  // Address split for the live request and for the latched bus address
  assign idx       = addr[OFF_W +: IDX_W];
  assign tag_in    = addr[ADDR_W-1 -: TAG_W];
  assign lat_idx   = lat_word_q[IDX_W-1:0];
  assign lat_tag   = lat_word_q[WORD_W-1 -: TAG_W];
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag_in);
  assign unused_lo = ^addr[OFF_W-1:0];

  // Bus signals decode only from registered state and latches
  assign bus_req    = (state_q != IDLE);
  assign bus_we     = (state_q == WRITE);
  assign bus_addr   = bus_req ? {lat_word_q, OFF_W'(0)} : '0;
  assign bus_wdata  = bus_we ? lat_data_q : '0;
  assign read_data  = (mem_read && !stall) ? data_mem[idx] : '0;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, stall and datapath enables
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    do_lat    = 1'b0;
    do_wr_hit = 1'b0;
    do_fill   = 1'b0;
    do_flush  = 1'b0;
    inc_hit   = 1'b0;
    inc_miss  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!done_q) begin
          if (mem_write) begin
            stall     = 1'b1;
            do_lat    = 1'b1;
            do_wr_hit = hit;
            state_d   = WRITE;
          end else if (mem_read) begin
            if (hit) begin
              inc_hit = 1'b1;
            end else begin
              stall    = 1'b1;
              do_lat   = 1'b1;
              inc_miss = 1'b1;
              state_d  = FILL;
            end
          end
        end
        if (flush && !mem_read && !mem_write) do_flush = 1'b1;
      end
      FILL: begin
        stall = 1'b1;
        if (bus_ack) begin
          do_fill = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (bus_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: done pulse, valid bits, latches and hit/miss counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      valid_q    <= '0;
      lat_word_q <= '0;
      lat_data_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      done_q <= (state_q != IDLE) && bus_ack;
      if (do_flush)     valid_q          <= '0;
      else if (do_fill) valid_q[lat_idx] <= 1'b1;
      if (do_lat) begin
        lat_word_q <= addr[ADDR_W-1:OFF_W];
        lat_data_q <= write_data;
      end
      if (inc_hit && (hit_q != '1))   hit_q  <= hit_q + CNT_W'(1);
      if (inc_miss && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  // Line storage: tag and data contents need no reset
  always_ff @(posedge clock) begin
    if (do_wr_hit) begin
      data_mem[idx] <= write_data;
    end else if (do_fill) begin
      data_mem[lat_idx] <= bus_rdata;
      tag_mem[lat_idx]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: reset, miss/hit, conflict, write-through,
// priority/flush and reset abort of a bus transaction.
module tb_dcache_ctrl;

  logic        clock, reset_n, mem_read, mem_write, flush;
  logic        stall, bus_req, bus_we, bus_ack;
  logic [31:0] addr, bus_addr;
  logic [63:0] write_data, read_data, bus_wdata, bus_rdata;
  logic [15:0] hit_count, miss_count;
  int          n_cmp = 0;
  int          n_bad = 0;

  dcache_ctrl dut (
    .clock(clock), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .flush(flush), .read_data(read_data),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From a miss request cycle: one bus_req cycle, then ack with data d
  task automatic fill_ack(input logic [63:0] d);
    tick();
    bus_rdata = d;
    bus_ack   = 1'b1;
    tick();
    bus_ack   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    bus_ack = 1'b0; addr = '0; write_data = '0; bus_rdata = '0;
    tick(); tick(); #2;
    n_cmp++; if (stall !== 1'b0)      begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (bus_req !== 1'b0)    begin n_bad++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
    n_cmp++; if (bus_we !== 1'b0)     begin n_bad++; $display("FAIL rst_bus_we: got %b want 0", bus_we); end
    n_cmp++; if (bus_addr !== 32'h0)  begin n_bad++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
    n_cmp++; if (bus_wdata !== 64'h0) begin n_bad++; $display("FAIL rst_bus_wdata: got %h want 0", bus_wdata); end
    n_cmp++; if (read_data !== 64'h0) begin n_bad++; $display("FAIL rst_read_data: got %h want 0", read_data); end
    n_cmp++; if (hit_count !== 16'h0) begin n_bad++; $display("FAIL rst_hit_count: got %0d want 0", hit_count); end
    n_cmp++; if (miss_count !== 16'h0) begin n_bad++; $display("FAIL rst_miss_count: got %0d want 0", miss_count); end
    reset_n = 1'b1;
    tick();
    mem_read = 1'b1; addr = 32'h48; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL first_miss_stall: got %b want 1", stall); end
    tick(); #2;
    n_cmp++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL first_miss_count: got %0d want 1", miss_count); end
    n_cmp++; if (bus_req !== 1'b1)     begin n_bad++; $display("FAIL first_bus_req: got %b want 1", bus_req); end
    n_cmp++; if (bus_we !== 1'b0)      begin n_bad++; $display("FAIL first_bus_we: got %b want 0", bus_we); end
    n_cmp++; if (bus_addr !== 32'h48)  begin n_bad++; $display("FAIL first_bus_addr: got %h want 48", bus_addr); end
    #1; reset_n = 1'b0; mem_read = 1'b0; #1;
    n_cmp++; if (bus_req !== 1'b0)     begin n_bad++; $display("FAIL midcyc_rst_bus_req: got %b want 0", bus_req); end
    n_cmp++; if (miss_count !== 16'd0) begin n_bad++; $display("FAIL midcyc_rst_miss: got %0d want 0", miss_count); end
    tick(); reset_n = 1'b1; tick();
  endtask

  task automatic test_read_miss_hit();
    int stalls = 0;
    mem_read = 1'b1; addr = 32'h4C;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (stall) stalls++;
      if (c == 1) begin
        n_cmp++; if (bus_addr !== 32'h48) begin n_bad++; $display("FAIL miss_bus_addr: got %h want 48", bus_addr); end
      end
      if (c == 3) begin
        bus_rdata = 64'hDEADBEEF01234567;
        bus_ack   = 1'b1;
      end
      tick();
      bus_ack = 1'b0;
    end
    #2;
    n_cmp++; if (stalls != 4)          begin n_bad++; $display("FAIL miss_stall_cycles: got %0d want 4", stalls); end
    n_cmp++; if (stall !== 1'b0)       begin n_bad++; $display("FAIL miss_done_stall: got %b want 0", stall); end
    n_cmp++; if (read_data !== 64'hDEADBEEF01234567) begin n_bad++; $display("FAIL miss_data: got %h want deadbeef01234567", read_data); end
    n_cmp++; if (bus_req !== 1'b0)     begin n_bad++; $display("FAIL miss_req_drop: got %b want 0", bus_req); end
    n_cmp++; if (miss_count !== 16'd1) begin n_bad++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
    tick();
    addr = 32'h48; #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hit_stall: got %b want 0", stall); end
    n_cmp++; if (read_data !== 64'hDEADBEEF01234567) begin n_bad++; $display("FAIL hit_data: got %h want deadbeef01234567", read_data); end
    tick(); mem_read = 1'b0; #2;
    n_cmp++; if (hit_count !== 16'd1) begin n_bad++; $display("FAIL hit_count1: got %0d want 1", hit_count); end
    tick();
  endtask

  task automatic test_conflict();
    mem_read = 1'b1; addr = 32'hC8; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL conflict_miss: got %b want 1", stall); end
    fill_ack(64'hC8C8C8C800000001); #2;
    n_cmp++; if (read_data !== 64'hC8C8C8C800000001) begin n_bad++; $display("FAIL conflict_data: got %h want c8c8c8c800000001", read_data); end
    tick();
    addr = 32'h48; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL evicted_miss: got %b want 1", stall); end
    fill_ack(64'hDEADBEEF01234567); #2;
    n_cmp++; if (miss_count !== 16'd3) begin n_bad++; $display("FAIL miss_count3: got %0d want 3", miss_count); end
    n_cmp++; if (read_data !== 64'hDEADBEEF01234567) begin n_bad++; $display("FAIL refill_data: got %h want deadbeef01234567", read_data); end
    tick(); mem_read = 1'b0; tick();
  endtask

  task automatic test_write_through();
    mem_write = 1'b1; addr = 32'h48; write_data = 64'h1111; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL wr_stall: got %b want 1", stall); end
    tick(); #2;
    n_cmp++; if (bus_req !== 1'b1)     begin n_bad++; $display("FAIL wr_bus_req: got %b want 1", bus_req); end
    n_cmp++; if (bus_we !== 1'b1)      begin n_bad++; $display("FAIL wr_bus_we: got %b want 1", bus_we); end
    n_cmp++; if (bus_addr !== 32'h48)  begin n_bad++; $display("FAIL wr_bus_addr: got %h want 48", bus_addr); end
    n_cmp++; if (bus_wdata !== 64'h1111) begin n_bad++; $display("FAIL wr_bus_wdata: got %h want 1111", bus_wdata); end
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; #2;
    n_cmp++; if (stall !== 1'b0)   begin n_bad++; $display("FAIL wr_done_stall: got %b want 0", stall); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL wr_req_drop: got %b want 0", bus_req); end
    tick();
    mem_write = 1'b0; mem_read = 1'b1; addr = 32'h48; #2;
    n_cmp++; if (stall !== 1'b0)        begin n_bad++; $display("FAIL wr_hit_stall: got %b want 0", stall); end
    n_cmp++; if (read_data !== 64'h1111) begin n_bad++; $display("FAIL wr_hit_data: got %h want 1111", read_data); end
    n_cmp++; if (bus_req !== 1'b0)      begin n_bad++; $display("FAIL wr_hit_no_req: got %b want 0", bus_req); end
    tick(); mem_read = 1'b0; #2;
    n_cmp++; if (hit_count !== 16'd2) begin n_bad++; $display("FAIL hit_count2: got %0d want 2", hit_count); end
    mem_write = 1'b1; addr = 32'h200; write_data = 64'hABCD;
    tick(); #2;
    n_cmp++; if (bus_we !== 1'b1)        begin n_bad++; $display("FAIL wmiss_bus_we: got %b want 1", bus_we); end
    n_cmp++; if (bus_addr !== 32'h200)   begin n_bad++; $display("FAIL wmiss_bus_addr: got %h want 200", bus_addr); end
    n_cmp++; if (bus_wdata !== 64'hABCD) begin n_bad++; $display("FAIL wmiss_bus_wdata: got %h want abcd", bus_wdata); end
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; tick();
    mem_write = 1'b0; mem_read = 1'b1; addr = 32'h200; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL no_allocate: got %b want 1", stall); end
    fill_ack(64'h0200); #2;
    n_cmp++; if (read_data !== 64'h0200) begin n_bad++; $display("FAIL fill200_data: got %h want 200", read_data); end
    n_cmp++; if (miss_count !== 16'd4)   begin n_bad++; $display("FAIL miss_count4: got %0d want 4", miss_count); end
    tick(); mem_read = 1'b0; tick();
  endtask

  task automatic test_priority_flush();
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h48; write_data = 64'h2222; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL prio_stall: got %b want 1", stall); end
    tick(); #2;
    n_cmp++; if (bus_we !== 1'b1)      begin n_bad++; $display("FAIL prio_is_write: got %b want 1", bus_we); end
    n_cmp++; if (miss_count !== 16'd4) begin n_bad++; $display("FAIL prio_no_miss: got %0d want 4", miss_count); end
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; #2;
    n_cmp++; if (read_data !== 64'h2222) begin n_bad++; $display("FAIL prio_done_data: got %h want 2222", read_data); end
    tick();
    mem_write = 1'b0; flush = 1'b1; #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_with_access: got %b want 0", stall); end
    tick(); flush = 1'b0; #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_ignored: got %b want 0", stall); end
    tick(); mem_read = 1'b0; #2;
    n_cmp++; if (hit_count !== 16'd4) begin n_bad++; $display("FAIL hit_count4: got %0d want 4", hit_count); end
    flush = 1'b1; tick(); flush = 1'b0;
    mem_read = 1'b1; addr = 32'h48; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_miss: got %b want 1", stall); end
    fill_ack(64'h3333); #2;
    n_cmp++; if (miss_count !== 16'd5)   begin n_bad++; $display("FAIL miss_count5: got %0d want 5", miss_count); end
    n_cmp++; if (read_data !== 64'h3333) begin n_bad++; $display("FAIL flush_fill_data: got %h want 3333", read_data); end
    tick(); mem_read = 1'b0; tick();
  endtask

  task automatic test_abort();
    mem_read = 1'b1; addr = 32'hC8; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL abort_miss: got %b want 1", stall); end
    tick(); #2;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL abort_req_up: got %b want 1", bus_req); end
    #1; reset_n = 1'b0; mem_read = 1'b0; #1;
    n_cmp++; if (bus_req !== 1'b0)    begin n_bad++; $display("FAIL abort_req_drop: got %b want 0", bus_req); end
    n_cmp++; if (stall !== 1'b0)      begin n_bad++; $display("FAIL abort_stall: got %b want 0", stall); end
    n_cmp++; if (hit_count !== 16'd0) begin n_bad++; $display("FAIL abort_hit_clr: got %0d want 0", hit_count); end
    tick(); reset_n = 1'b1; tick();
    bus_rdata = 64'hBAD0BAD0BAD0BAD0; bus_ack = 1'b1; #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stray_ack_stall: got %b want 0", stall); end
    tick(); bus_ack = 1'b0; #2;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL stray_ack_req: got %b want 0", bus_req); end
    n_cmp++; if (stall !== 1'b0)   begin n_bad++; $display("FAIL stray_ack_stall2: got %b want 0", stall); end
    tick();
    mem_read = 1'b1; addr = 32'hC8; #2;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stray_no_update: got %b want 1", stall); end
    fill_ack(64'h5555); #2;
    n_cmp++; if (read_data !== 64'h5555) begin n_bad++; $display("FAIL post_abort_data: got %h want 5555", read_data); end
    tick(); mem_read = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_conflict();
    test_write_through();
    test_priority_flush();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
